spi_mem_loader: RTL
===================

Name: spi_mem_loader

Overview:
- Serial configuration loader that sits directly upstream of the synapse weight/delay memory (M words of N bits).
- Receives an SPI mode-0 byte stream from the chip pins: a 16-bit start address header followed by data words.
- Issues one write (mem_we/mem_addr/mem_data) per received word, auto-incrementing the address with wrap-around.
- Lets the off-chip host program the network's weights and delays before it runs.

Parameters:
- M, 320, number of memory words; addresses are 0..M-1.
- N, 8, data word width in bits; each data word is N serial bits.
- AW, $clog2(M), memory address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- sclk  input  1  SPI clock from the pin, asynchronous to clk.
- mosi  input  1  SPI serial data from the pin, MSB first, sampled on the sclk rising edge.
- cs_n  input  1  SPI chip select from the pin, active-low; frames the transfer.
- mem_data  output  N  write data to the memory.
- mem_addr  output  AW  write address to the memory.
- mem_we  output  1  one-cycle write strobe to the memory.
- busy  output  1  high while a frame is open (synchronized cs_n low).
- frame_done  output  1  one-cycle pulse when a frame closes.
- addr_error  output  1  sticky flag: the last header address was >= M.
- write_count  output  AW+1  number of words written in the current or last frame; saturates at 2^(AW+1)-1.

Behaviour:
- Synchronization
  - sclk, mosi and cs_n each pass through a 2-flop synchronizer.
  - Reset values: sclk 0, mosi 0, cs_n 1.
  - An sclk rising edge is detected when sync stage 2 = 1 and its delayed copy = 0.
  - clk must be >= 4x the sclk frequency. A slower clk is not supported and is not checked.
- Bit handling
  - On each detected rising edge while the frame is open, mosi (synchronized) is shifted into the shift register LSB and the bit counter increments.
- State machine: IDLE, ADDR (16 bits), DATA, DISCARD.
  - IDLE -> ADDR when synchronized cs_n falls; the bit counter clears and write_count clears.
  - ADDR -> DATA after 16 bits, if the header value < M; mem_addr loads header[AW-1:0].
  - ADDR -> DISCARD after 16 bits, if the header value >= M; addr_error is set.
  - A header value < M clears addr_error.
  - DATA: every N bits completes one word.
    - mem_data <= word and mem_we = 1 for exactly one clk, in the cycle after the edge that shifted the last bit in.
    - mem_addr is stable during the strobe.
    - mem_addr increments on the clk following the strobe; M-1 wraps to 0.
    - write_count increments with each strobe.
  - DISCARD: bits are ignored; no writes are issued.
  - Any state -> IDLE when synchronized cs_n rises; frame_done pulses for 1 clk.
    - A partial word or partial header is dropped; no write is issued for it.
    - frame_done does not pulse if cs_n was already high.
- Latency
  - The sclk rising edge carrying the last bit of a word reaches the pin at clk edge k.
  - mem_we is high in the cycle that starts at clk edge k+4.
- Reset values
  - mem_data 0, mem_addr 0, mem_we 0, busy 0, frame_done 0, addr_error 0, write_count 0; state IDLE.
  - Reset mid-frame aborts the frame with no write.
  - After reset is released, a frame already in progress (cs_n already low) is ignored until cs_n goes high and low again.
- Edge cases
  - A data word completing in the same cycle that cs_n rise is detected is written; the word is complete, so it is not treated as partial.
  - mem_we never asserts outside DATA.
- busy equals the inverse of synchronized cs_n, gated by not-IDLE-after-reset-mid-frame.

Test Plan:
- Header 0x0000, data 0x11,0x22,0x33, then cs_n high -> three writes at addr 0,1,2 with data 0x11,0x22,0x33; write_count=3; one frame_done pulse; addr_error=0.
- Header 0x013E (318), four data bytes 0xA0..0xA3 -> writes at addr 318,319,0,1 (wrap verified).
- Header 0x0140 (320), then two data bytes -> no mem_we; addr_error=1. A following frame with header 0x0005 clears addr_error and writes at addr 5.
- Header 0x0010, one byte 0x5A, then 5 more bits before cs_n rises -> exactly one write (addr 16, 0x5A); the partial word is dropped; frame_done pulses once.
- Assert reset after 12 header bits, release it while cs_n is still low, continue clocking -> no writes. A new frame after cs_n toggles works normally.
- Latency check at clk = 4x sclk: mem_we rises exactly 4 clk edges after the 8th data sclk rising edge; mem_addr/mem_data are stable for the whole strobe cycle.

Source files
------------

// File: rtl/spi_mem_loader.sv
// SPI mode-0 configuration loader: a 16-bit start address followed by N-bit words,
// written to the synapse memory with an auto-incrementing, wrapping address.
module spi_mem_loader #(
  parameter int unsigned M  = 320,
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          cs_n,
  output logic [N-1:0]  mem_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          busy,
  output logic          frame_done,
  output logic          addr_error,
  output logic [AW:0]   write_count
);

  localparam int unsigned HW  = 16;
  localparam int unsigned CW  = 5;
  localparam int unsigned WCW = AW + 1;
  localparam logic [WCW-1:0] WC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DISCARD} state_t;

  logic          sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic          mosi_s1_q, mosi_s2_q;
  logic          cs_s1_q, cs_s2_q;
  logic [1:0]    settle_q;
  logic          armed_q;
  logic          ev_bit_q, ev_mosi_q, ev_low_q;

  state_t        state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [HW-2:0] shift_q, shift_d;
  logic          word_rdy_q, word_rdy_d;
  logic          frame_done_q, frame_done_d;
  logic          addr_error_q, addr_error_d;
  logic          busy_q;
  logic          mem_we_q;
  logic [N-1:0]  mem_data_q;
  logic [AW-1:0] mem_addr_q;
  logic [WCW-1:0] write_count_q;

  logic [HW-1:0] hdr_c;
  logic          hdr_ok_c;
  logic          hdr_load_c;
  logic          wc_clr_c;

  // Pin synchronizers plus one event stage that keeps bit strobes and frame
  // open/close aligned. cs_n is only honoured once it has been seen high
  // after reset, so a frame already open at reset release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      settle_q  <= 2'd0;
      armed_q   <= 1'b0;
      ev_bit_q  <= 1'b0;
      ev_mosi_q <= 1'b0;
      ev_low_q  <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_d_q  <= sclk_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      settle_q  <= (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      armed_q   <= armed_q | ((settle_q == 2'd2) & cs_s2_q);
      ev_bit_q  <= sclk_s2_q & ~sclk_d_q;
      ev_mosi_q <= mosi_s2_q;
      ev_low_q  <= armed_q & ~cs_s2_q;
    end
  end

  assign hdr_c    = {shift_q, ev_mosi_q};
  assign hdr_ok_c = (hdr_c < HW'(M));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      word_rdy_q   <= 1'b0;
      frame_done_q <= 1'b0;
      addr_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      word_rdy_q   <= word_rdy_d;
      frame_done_q <= frame_done_d;
      addr_error_q <= addr_error_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    word_rdy_d   = 1'b0;
    frame_done_d = 1'b0;
    addr_error_d = addr_error_q;
    hdr_load_c   = 1'b0;
    wc_clr_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_low_q) begin
          state_d  = S_ADDR;
          bitcnt_d = '0;
          wc_clr_c = 1'b1;
        end
      end
      S_ADDR: begin
        if (ev_bit_q) begin
          shift_d = hdr_c[HW-2:0];
          if (bitcnt_q == CW'(HW - 1)) begin
            bitcnt_d = '0;
            if (hdr_ok_c) begin
              state_d      = S_DATA;
              hdr_load_c   = 1'b1;
              addr_error_d = 1'b0;
            end else begin
              state_d      = S_DISCARD;
              addr_error_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (ev_bit_q) begin
          shift_d = hdr_c[HW-2:0];
          if (bitcnt_q == CW'(N - 1)) begin
            bitcnt_d   = '0;
            word_rdy_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
    // A word completing alongside the close is still flagged above and written.
    if ((state_q != S_IDLE) && !ev_low_q) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b1;
    end
  end

  // Memory write port: strobe follows the shift that completed the word;
  // the address advances the cycle after the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_q      <= 1'b0;
      mem_data_q    <= '0;
      mem_addr_q    <= '0;
      write_count_q <= '0;
    end else begin
      mem_we_q <= word_rdy_q;
      if (word_rdy_q) begin
        mem_data_q <= shift_q[N-1:0];
      end
      if (hdr_load_c) begin
        mem_addr_q <= hdr_c[AW-1:0];
      end else if (mem_we_q) begin
        mem_addr_q <= (mem_addr_q == AW'(M - 1)) ? '0 : mem_addr_q + AW'(1);
      end
      if (wc_clr_c) begin
        write_count_q <= '0;
      end else if (word_rdy_q && (write_count_q != WC_MAX)) begin
        write_count_q <= write_count_q + WCW'(1);
      end
    end
  end

  assign mem_data    = mem_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign addr_error  = addr_error_q;
  assign write_count = write_count_q;

endmodule
